// File: rtl/tensor_collect.sv
// ----------------------------------------------------------------------------
// tensor_collect
//   Gathers a stream of IN_CH*IN_H*IN_W signed elements (channel-major, then
//   row, then column) into one flattened vector for a conv2d in_vec. A
//   two-state FSM fills the vector beat by beat, then presents it until
//   downstream takes it.
//
// Parameters
//   IN_CH, IN_H, IN_W : frame geometry, N = IN_CH*IN_H*IN_W elements
//   WIDTH             : element width (signed, passed through unchanged)
//
// Ports
//   clk       : single clock, rising edge
//   rst_n     : synchronous active-low reset
//   in_data   : streamed element
//   in_valid  : in_data valid
//   in_ready  : block accepts in_data this cycle (high in FILL)
//   in_last   : final element of the frame (used only with framing checks)
//   out_vec   : flattened frame, element n at [n*WIDTH +: WIDTH]
//   out_valid : out_vec holds a complete frame (high in FULL)
//   out_ready : downstream consumes the frame
//   err       : sticky framing error
//
// Configuration
//   TENSOR_COLLECT_LAST_CHECK_EN : when defined, in_last is checked against
//   the element count and mismatches set err; when undefined, in_last is
//   ignored and err is tied to 0.
// ----------------------------------------------------------------------------
module tensor_collect #(
    parameter int IN_CH = 1,
    parameter int IN_H  = 1,
    parameter int IN_W  = 1,
    parameter int WIDTH = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic signed [WIDTH-1:0]             in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                in_last,
    output logic signed [IN_CH*IN_H*IN_W*WIDTH-1:0] out_vec,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                err
);

    localparam int N     = IN_CH * IN_H * IN_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             wr_en;

`ifdef TENSOR_COLLECT_LAST_CHECK_EN
    logic err_q;
    logic err_set;
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
`endif

    // Next-state, counter and handshake decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_next = state;
        cnt_next   = cnt;
        wr_en      = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
`ifdef TENSOR_COLLECT_LAST_CHECK_EN
        err_set    = 1'b0;
`endif
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (cnt == LAST_IDX) begin
                        cnt_next   = '0;
                        state_next = FULL;
`ifdef TENSOR_COLLECT_LAST_CHECK_EN
                        // Missing in_last on the final element is flagged,
                        // but the frame itself is still complete.
                        err_set = !in_last;
`endif
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
`ifdef TENSOR_COLLECT_LAST_CHECK_EN
                        // Early in_last: drop the partial frame and restart.
                        if (in_last) begin
                            err_set  = 1'b1;
                            cnt_next = '0;
                        end
`endif
                    end
                end
            end
            FULL: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = FILL;
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    // State, counter, frame storage and error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: out_vec is a register bank, not a RAM, so clearing it on
            // reset is cheap and gives downstream a defined value.
            state   <= FILL;
            cnt     <= '0;
            out_vec <= '0;
`ifdef TENSOR_COLLECT_LAST_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state <= state_next;
            cnt   <= cnt_next;
            if (wr_en) begin
                for (int i = 0; i < N; i++) begin
                    if (cnt == CNT_W'(i)) begin
                        out_vec[i*WIDTH +: WIDTH] <= in_data;
                    end
                end
            end
`ifdef TENSOR_COLLECT_LAST_CHECK_EN
            if (err_set) begin
                err_q <= 1'b1;
            end
`endif
        end
    end

`ifdef TENSOR_COLLECT_LAST_CHECK_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tensor_collect.sv
// ----------------------------------------------------------------------------
// tb_tensor_collect
//   Self-checking bench for tensor_collect. One instance uses a 1x2x2 frame,
//   a second uses the 1x1x1 frame. Expected frames are queued when the bench
//   drives their final beat and compared when the DUT hands the frame off.
//   Inputs change on the falling edge; the monitors sample 2 ns later.
// ----------------------------------------------------------------------------
module tb_tensor_collect;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic rst_n;

    // 1x2x2 instance
    logic [W-1:0]  in_data;
    logic          in_valid, in_last, out_ready;
    logic          in_ready, out_valid, err;
    logic [4*W-1:0] out_vec;

    // 1x1x1 instance
    logic [W-1:0]  in_data1;
    logic          in_valid1, in_last1, out_ready1;
    logic          in_ready1, out_valid1, err1;
    logic [W-1:0]  out_vec1;

    tensor_collect #(.IN_CH(1), .IN_H(2), .IN_W(2), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .out_vec   (out_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    tensor_collect #(.IN_CH(1), .IN_H(1), .IN_W(1), .WIDTH(W)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_last   (in_last1),
        .out_vec   (out_vec1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .err       (err1)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [4*W-1:0] exp_q[$];
    logic [W-1:0]   exp1_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboards: a frame is consumed when out_valid && out_ready.
    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("sb_unexpected", 64'd1, 64'd0);
            else                   check("sb_frame", out_vec, exp_q.pop_front());
        end
    end

    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid1 && out_ready1) begin
            if (exp1_q.size() == 0) check("sb1_unexpected", 64'd1, 64'd0);
            else                    check("sb1_frame", {48'd0, out_vec1}, {48'd0, exp1_q.pop_front()});
        end
    end

    // Present one beat at a falling edge and return at the falling edge
    // after it was accepted.
    task automatic send_beat(input logic [W-1:0] d, input logic l);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("beat_timeout", 64'd0, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Stream a whole frame; last_at selects the beat carrying in_last
    // (-1 for none), gaps inserts one idle cycle between beats.
    task automatic send_frame(input logic [4*W-1:0] v, input int last_at,
                              input bit gaps, input bit push);
        for (int i = 0; i < 4; i++) begin
            if (i == 3 && push) exp_q.push_back(v);
            send_beat(v[i*W +: W], (i == last_at));
            if (gaps && i < 3) @(negedge clk);
        end
    endtask

    task automatic send_beat1(input logic [W-1:0] d);
        int t = 0;
        in_valid1 = 1'b1;
        in_data1  = d;
        in_last1  = 1'b1;
        exp1_q.push_back(d);
        while (!in_ready1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready1) check("beat1_timeout", 64'd0, 64'd1);
        @(negedge clk);
        in_valid1 = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam logic [63:0] F1 = 64'hFFFF_0003_0002_0001;
    localparam logic [63:0] F2 = 64'h000D_000C_000B_000A;
    localparam logic [63:0] F3 = 64'h0034_0033_0032_0031;

    initial begin
        int c0;
        int bad;
        logic [W-1:0] d1 [3];

        rst_n      = 1'b0;
        in_data    = '0; in_valid  = 1'b0; in_last  = 1'b0; out_ready  = 1'b0;
        in_data1   = '0; in_valid1 = 1'b0; in_last1 = 1'b0; out_ready1 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst_in_ready",   in_ready,  1);
        check("rst_out_valid",  out_valid, 0);
        check("rst_out_vec",    out_vec,   0);
        check("rst_err",        err,       0);
        check("rst1_in_ready",  in_ready1, 1);
        check("rst1_out_valid", out_valid1, 0);

        // Basic fill, back-to-back beats, out_ready held high
        out_ready = 1'b1;
        c0 = cyc;
        send_frame(F1, 3, 1'b0, 1'b1);
        check("basic_cycles",    cyc - c0, 4);
        check("basic_out_valid", out_valid, 1);
        check("basic_in_ready",  in_ready, 0);
        check("basic_out_vec",   out_vec, F1);
        @(negedge clk);
        check("basic_refill_valid", out_valid, 0);
        check("basic_refill_ready", in_ready, 1);

        // Backpressure: frame held 10 cycles while in_valid stays high
        out_ready = 1'b0;
        send_frame(F1, 3, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_vec !== F1) bad++;
        end
        check("bp_hold", bad, 0);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);

        // Gaps between beats; counter must still start at element 0
        c0 = cyc;
        send_frame(F1, 3, 1'b1, 1'b1);
        check("gap_cycles",    cyc - c0, 7);
        check("gap_out_valid", out_valid, 1);
        check("gap_out_vec",   out_vec, F1);
        @(negedge clk);

        // Reset during a partial fill
        send_beat(16'h0055, 1'b0);
        send_beat(16'h0066, 1'b0);
        pulse_reset();
        check("midrst_out_vec",  out_vec, 0);
        check("midrst_in_ready", in_ready, 1);
        send_frame(F2, 3, 1'b0, 1'b1);
        check("midrst_valid", out_valid, 1);
        check("midrst_vec",   out_vec, F2);
        check("midrst_err",   err, 0);
        @(negedge clk);

        // Reset while FULL discards the frame
        out_ready = 1'b0;
        send_frame(F1, 3, 1'b0, 1'b0);
        check("fullrst_pre_valid", out_valid, 1);
        pulse_reset();
        check("fullrst_valid", out_valid, 0);
        check("fullrst_vec",   out_vec, 0);
        out_ready = 1'b1;

`ifdef TENSOR_COLLECT_LAST_CHECK_EN
        // Missing in_last on the final element: flagged, still delivered
        send_frame(F3, -1, 1'b0, 1'b1);
        check("nolast_valid", out_valid, 1);
        check("nolast_err",   err, 1);
        @(negedge clk);
        pulse_reset();
        check("nolast_rst_err", err, 0);

        // Early in_last: frame dropped, err sticky, next frame delivered
        send_beat(16'h0011, 1'b0);
        send_beat(16'h0022, 1'b1);
        check("early_err",      err, 1);
        check("early_no_valid", out_valid, 0);
        check("early_in_ready", in_ready, 1);
        send_frame(F3, 3, 1'b0, 1'b1);
        check("early_next_valid", out_valid, 1);
        check("early_next_vec",   out_vec, F3);
        check("early_err_sticky", err, 1);
        @(negedge clk);
`else
        // in_last ignored: a stray in_last neither errors nor truncates
        send_frame(F3, 1, 1'b0, 1'b1);
        check("ign_last_valid", out_valid, 1);
        check("ign_last_vec",   out_vec, F3);
        check("ign_last_err",   err, 0);
        @(negedge clk);
`endif

        // N=1: every beat is a frame, period 2 cycles with out_ready high
        out_ready1 = 1'b1;
        d1[0] = 16'h1234;
        d1[1] = 16'h8001;
        d1[2] = 16'h1234;
        c0 = cyc;
        for (int i = 0; i < 3; i++) begin
            send_beat1(d1[i]);
            check("n1_out_valid", out_valid1, 1);
            check("n1_out_vec",   {48'd0, out_vec1}, {48'd0, d1[i]});
        end
        check("n1_cycles", cyc - c0, 5);
        @(negedge clk);
        check("n1_refill_ready", in_ready1, 1);
        check("n1_err", err1, 0);

        repeat (3) @(negedge clk);
        check("sb_drained",  exp_q.size(), 0);
        check("sb1_drained", exp1_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
